tdm_demux4: RTL and testbench

Receive-side counterpart of the team's 4-to-1 multiplexer path: recovers four parallel channels from a bit-interleaved time-division-multiplexed serial stream. A 2-bit slot counter, matching the mux's select sequencing, steers each accepted bit into one of four channel shift registers. A frame-sync input locks the counter. Once every channel holds a full word, the four words are presented together with a one-cycle valid strobe.

---
 rtl/tdm_demux4.sv | 152 +++++++++++++++
 tb/tb_tdm_demux4.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// tdm_demux4: recovers four parallel channel words from a bit-interleaved
// TDM serial stream. A frame-sync bit locks a 2-bit slot counter that
// steers each accepted bit into one of four MSB-first shift registers.
// Once all four words are complete they are presented together with a
// one-cycle valid strobe.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_HUNT   | waiting for frame_sync; accepted bits without it are dropped
//   S_LOCKED | slot counter running; bits steered to channel shift regs
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic [WIDTH-1:0] dout2,
  output logic [WIDTH-1:0] dout3,
  output logic             dout_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             sync_err
);

  // Bit counter counts completed slot rounds within a frame (0..WIDTH-1).
  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_slot;
  logic [1:0]       w_slot_nxt;
  logic [CW-1:0]    r_bitcnt;
  logic [CW-1:0]    w_bitcnt_nxt;
  logic [WIDTH-1:0] r_shreg     [4];
  logic [WIDTH-1:0] w_shreg_nxt [4];
  logic [WIDTH-1:0] r_dout      [4];
  logic [3:0]       w_shift_en;
  logic             w_complete;
  logic             w_resync;
  logic             r_dout_valid;
  logic             r_sync_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, slot/bit-counter sequencing and frame event decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_slot_nxt   = r_slot;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_en   = 4'b0000;
    w_complete   = 1'b0;
    w_resync     = 1'b0;
    if (din_valid) begin
      case (r_state)
        S_HUNT: begin
          if (frame_sync) begin
            w_state_nxt  = S_LOCKED;
            w_slot_nxt   = 2'd1;
            w_bitcnt_nxt = '0;
            w_shift_en   = 4'b0001;
          end
        end
        S_LOCKED: begin
          if (frame_sync && (r_slot != 2'd0)) begin
            // Misplaced sync: restart the frame on this bit as ch0 MSB.
            w_resync     = 1'b1;
            w_slot_nxt   = 2'd1;
            w_bitcnt_nxt = '0;
            w_shift_en   = 4'b0001;
          end else begin
            w_shift_en = 4'b0001 << r_slot;
            w_slot_nxt = r_slot + 2'd1;
            if (r_slot == 2'd3) begin
              if (r_bitcnt == LAST_BIT) begin
                w_complete   = 1'b1;
                w_bitcnt_nxt = '0;
              end else begin
                w_bitcnt_nxt = r_bitcnt + CW'(1);
              end
            end
          end
        end
        default: begin
          w_state_nxt = S_HUNT;
        end
      endcase
    end
  end

  // Shift-register next values; the shift form is also valid for WIDTH = 1.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_shreg_nxt[k] = r_shreg[k];
      if (w_shift_en[k]) begin
        w_shreg_nxt[k] = (r_shreg[k] << 1) | WIDTH'(din);
      end
    end
  end

  // Datapath registers: slot, bit counter, shift registers, outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot       <= 2'd0;
      r_bitcnt     <= '0;
      r_dout_valid <= 1'b0;
      r_sync_err   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_shreg[k] <= '0;
        r_dout[k]  <= '0;
      end
    end else begin
      r_slot       <= w_slot_nxt;
      r_bitcnt     <= w_bitcnt_nxt;
      r_dout_valid <= w_complete;
      r_sync_err   <= w_resync;
      for (int k = 0; k < 4; k++) begin
        r_shreg[k] <= w_shreg_nxt[k];
        // Completion snapshot includes the ch3 bit shifted in this edge.
        if (w_complete) begin
          r_dout[k] <= w_shreg_nxt[k];
        end
      end
    end
  end

  assign dout0      = r_dout[0];
  assign dout1      = r_dout[1];
  assign dout2      = r_dout[2];
  assign dout3      = r_dout[3];
  assign dout_valid = r_dout_valid;
  assign slot       = r_slot;
  assign locked     = (r_state == S_LOCKED);
  assign sync_err   = r_sync_err;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: scoreboard bench for tdm_demux4 (WIDTH = 8). Expected
// frames are queued when their first bit is driven and popped when the
// DUT strobes dout_valid; a small slot/lock model checks every cycle.
module tb_tdm_demux4;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         din;
  logic         din_valid;
  logic         frame_sync;
  logic [W-1:0] dout0, dout1, dout2, dout3;
  logic         dout_valid;
  logic [1:0]   slot;
  logic         locked;
  logic         sync_err;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .dout0      (dout0),
    .dout1      (dout1),
    .dout2      (dout2),
    .dout3      (dout3),
    .dout_valid (dout_valid),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] m_dout;
  logic [1:0]  m_slot;
  logic        m_locked;
  int          bits_since;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Drive one accepted bit; last marks the bit that must complete a frame.
  task automatic send_bit(input logic b, input logic fs, input logic last);
    logic        exp_serr;
    logic [31:0] exp_f;
    exp_serr = 1'b0;
    if (m_locked) begin
      if (fs && m_slot != 2'd0) begin
        exp_serr   = 1'b1;
        m_slot     = 2'd1;
        bits_since = 1;
      end else begin
        m_slot     = m_slot + 2'd1;
        bits_since = bits_since + 1;
      end
    end else if (fs) begin
      m_locked   = 1'b1;
      m_slot     = 2'd1;
      bits_since = 1;
    end
    din        = b;
    din_valid  = 1'b1;
    frame_sync = fs;
    @(posedge clk); #1;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    check("slot", {30'd0, slot}, {30'd0, m_slot});
    check("locked", {31'd0, locked}, {31'd0, m_locked});
    check("sync_err", {31'd0, sync_err}, {31'd0, exp_serr});
    check("dout_valid", {31'd0, dout_valid}, {31'd0, last});
    if (dout_valid) begin
      check("sb_pending", sb_q.size(), 1);
      check("spacing", bits_since, 4 * W);
      bits_since = 0;
      if (sb_q.size() > 0) begin
        exp_f  = sb_q.pop_front();
        m_dout = exp_f;
        check("dout0", {24'd0, dout0}, {24'd0, exp_f[31:24]});
        check("dout1", {24'd0, dout1}, {24'd0, exp_f[23:16]});
        check("dout2", {24'd0, dout2}, {24'd0, exp_f[15:8]});
        check("dout3", {24'd0, dout3}, {24'd0, exp_f[7:0]});
      end
    end
  endtask

  // Stalled cycles: random din/frame_sync with din_valid low must change nothing.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      din_valid  = 1'b0;
      din        = 1'($urandom);
      frame_sync = 1'($urandom);
      @(posedge clk); #1;
      frame_sync = 1'b0;
      check("idle_slot", {30'd0, slot}, {30'd0, m_slot});
      check("idle_locked", {31'd0, locked}, {31'd0, m_locked});
      check("idle_dout_valid", {31'd0, dout_valid}, 32'd0);
      check("idle_sync_err", {31'd0, sync_err}, 32'd0);
    end
    check("hold_douts", {dout0, dout1, dout2, dout3}, m_dout);
  endtask

  // Full frame, MSB first, bit-interleaved ch0..ch3, frame_sync on the first bit.
  task automatic send_frame(input logic [31:0] f, input logic stall);
    logic [W-1:0] w [4];
    w[0] = f[31:24]; w[1] = f[23:16]; w[2] = f[15:8]; w[3] = f[7:0];
    sb_q.push_back(f);
    for (int i = W - 1; i >= 0; i--) begin
      for (int k = 0; k < 4; k++) begin
        if (stall && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        send_bit(w[k][i], (i == W - 1) && (k == 0), (i == 0) && (k == 3));
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    din        = 1'b0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    m_dout     = 32'd0;
    m_slot     = 2'd0;
    m_locked   = 1'b0;
    bits_since = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset and idle.
    idle(20);

    // Basic frame.
    send_frame(32'hA53CFF01, 1'b0);
    idle(4);

    // Reset back to HUNT, discard 5 unsynced bits, then a stalled frame.
    rst_n = 1'b0;
    #2;
    m_locked = 1'b0; m_slot = 2'd0; m_dout = 32'd0; bits_since = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0, 1'b0);
    send_frame(32'hA53CFF01, 1'b1);
    idle(3);

    // Resync: six bits of a frame, then a frame whose sync lands on slot 2.
    send_bit(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1'b0, 1'b0);
    check("pre_resync_slot", {30'd0, slot}, 32'd2);
    send_frame(32'h11223344, 1'b0);
    idle(2);

    // Back-to-back frames.
    send_frame(32'hA53CFF01, 1'b0);
    send_frame(32'h5AC30080, 1'b0);

    // Reset mid-frame after 17 bits.
    send_bit(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) send_bit(1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    m_locked = 1'b0; m_slot = 2'd0; m_dout = 32'd0; bits_since = 0;
    check("rst_douts", {dout0, dout1, dout2, dout3}, m_dout);
    check("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_slot", {30'd0, slot}, 32'd0);
    check("rst_sync_err", {31'd0, sync_err}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    idle(3);
    send_frame(32'hDEADBEEF, 1'b0);
    idle(3);

    check("sb_drain", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
